// File: rtl/branch_predictor_btb.sv
// Direct-mapped BTB with 2-bit saturating direction counters.
// Combinational lookup for IF, mispredict/redirect for EXE, and saturating statistics.
module branch_predictor_btb #(
  parameter int unsigned PC_W     = 32,
  parameter int unsigned ENTRIES  = 16,
  parameter int unsigned CNT_INIT = 1,
  parameter int unsigned STAT_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              lookup_en,
  input  logic [PC_W-1:0]   lookup_pc,
  output logic              pred_taken,
  output logic [PC_W-1:0]   pred_target,
  input  logic              update_en,
  input  logic [PC_W-1:0]   update_pc,
  input  logic              update_taken,
  input  logic [PC_W-1:0]   update_target,
  input  logic              update_pred_taken,
  input  logic [PC_W-1:0]   update_pred_target,
  output logic              mispredict,
  output logic [PC_W-1:0]   redirect_pc,
  input  logic              clr_tbl,
  output logic [STAT_W-1:0] br_count,
  output logic [STAT_W-1:0] miss_count
);

  localparam int unsigned IDX_W   = $clog2(ENTRIES);
  localparam int unsigned TAG_W   = PC_W - IDX_W - 2;
  localparam logic [1:0]  CNT_RST = 2'(CNT_INIT);

  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [1:0]         cnt_q [ENTRIES];
  logic [1:0]         cnt_d [ENTRIES];
  logic [TAG_W-1:0]   tag_q [ENTRIES];
  logic [TAG_W-1:0]   tag_d [ENTRIES];
  logic [PC_W-1:0]    tgt_q [ENTRIES];
  logic [PC_W-1:0]    tgt_d [ENTRIES];
  logic [STAT_W-1:0]  br_count_q, br_count_d;
  logic [STAT_W-1:0]  miss_count_q, miss_count_d;

  logic [IDX_W-1:0] lk_idx, up_idx;
  logic [TAG_W-1:0] lk_tag, up_tag;
  logic             lk_hit, up_hit;

  assign lk_idx = lookup_pc[IDX_W+1:2];
  assign lk_tag = lookup_pc[PC_W-1:IDX_W+2];
  assign up_idx = update_pc[IDX_W+1:2];
  assign up_tag = update_pc[PC_W-1:IDX_W+2];
  assign lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

  // Lookup reads pre-update state only; no bypass from a same-cycle update.
  assign pred_taken  = !rst && lookup_en && lk_hit && cnt_q[lk_idx][1];
  assign pred_target = pred_taken ? tgt_q[lk_idx] : lookup_pc + PC_W'(4);

  assign mispredict  = !rst && update_en &&
                       ((update_taken != update_pred_taken) ||
                        (update_taken && (update_pred_target != update_target)));
  assign redirect_pc = update_taken ? update_target : update_pc + PC_W'(4);

  assign br_count   = br_count_q;
  assign miss_count = miss_count_q;

  always_comb begin
    valid_d = valid_q;
    cnt_d   = cnt_q;
    tag_d   = tag_q;
    tgt_d   = tgt_q;
    if (clr_tbl) begin
      valid_d = '0;
      for (int unsigned i = 0; i < ENTRIES; i++) cnt_d[i] = CNT_RST;
    end else if (update_en) begin
      if (up_hit) begin
        if (update_taken) begin
          if (cnt_q[up_idx] != 2'd3) cnt_d[up_idx] = cnt_q[up_idx] + 2'd1;
          tgt_d[up_idx] = update_target;
        end else if (cnt_q[up_idx] != 2'd0) begin
          cnt_d[up_idx] = cnt_q[up_idx] - 2'd1;
        end
      end else if (update_taken) begin
        valid_d[up_idx] = 1'b1;
        tag_d[up_idx]   = up_tag;
        tgt_d[up_idx]   = update_target;
        cnt_d[up_idx]   = 2'd2;
      end
    end
  end

  always_comb begin
    br_count_d   = br_count_q;
    miss_count_d = miss_count_q;
    if (update_en && (br_count_q != '1))   br_count_d   = br_count_q + STAT_W'(1);
    if (mispredict && (miss_count_q != '1)) miss_count_d = miss_count_q + STAT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q      <= '0;
      for (int unsigned i = 0; i < ENTRIES; i++) cnt_q[i] <= CNT_RST;
      br_count_q   <= '0;
      miss_count_q <= '0;
    end else begin
      valid_q      <= valid_d;
      cnt_q        <= cnt_d;
      br_count_q   <= br_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  // Tags and targets are qualified by valid, so they need no reset.
  always_ff @(posedge clk) begin
    tag_q <= tag_d;
    tgt_q <= tgt_d;
  end

endmodule

// File: tb/tb_branch_predictor_btb.sv
// Directed bench for branch_predictor_btb: expected values queued on drive, popped on compare.
module tb_branch_predictor_btb;

  logic        clk = 1'b0;
  logic        rst;
  logic        lookup_en;
  logic [31:0] lookup_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        update_en;
  logic [31:0] update_pc;
  logic        update_taken;
  logic [31:0] update_target;
  logic        update_pred_taken;
  logic [31:0] update_pred_target;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic        clr_tbl;
  logic [31:0] br_count;
  logic [31:0] miss_count;

  logic        pred_taken4;
  logic [31:0] pred_target4;
  logic        mispredict4;
  logic [31:0] redirect_pc4;
  logic [3:0]  br_count4;
  logic [3:0]  miss_count4;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned br_exp = 0;
  int unsigned miss_exp = 0;
  logic [63:0] sb[$];

  always #5 clk = ~clk;

  branch_predictor_btb #(.PC_W(32), .ENTRIES(16), .CNT_INIT(1), .STAT_W(32)) dut (
    .clk(clk), .rst(rst),
    .lookup_en(lookup_en), .lookup_pc(lookup_pc),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .update_en(update_en), .update_pc(update_pc), .update_taken(update_taken),
    .update_target(update_target), .update_pred_taken(update_pred_taken),
    .update_pred_target(update_pred_target),
    .mispredict(mispredict), .redirect_pc(redirect_pc),
    .clr_tbl(clr_tbl), .br_count(br_count), .miss_count(miss_count)
  );

  branch_predictor_btb #(.PC_W(32), .ENTRIES(16), .CNT_INIT(1), .STAT_W(4)) dut4 (
    .clk(clk), .rst(rst),
    .lookup_en(lookup_en), .lookup_pc(lookup_pc),
    .pred_taken(pred_taken4), .pred_target(pred_target4),
    .update_en(update_en), .update_pc(update_pc), .update_taken(update_taken),
    .update_target(update_target), .update_pred_taken(update_pred_taken),
    .update_pred_target(update_pred_target),
    .mispredict(mispredict4), .redirect_pc(redirect_pc4),
    .clr_tbl(clr_tbl), .br_count(br_count4), .miss_count(miss_count4)
  );

  task automatic expect_val(input logic [63:0] v);
    sb.push_back(v);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs);
    logic [63:0] e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL %s: observed %0h, scoreboard empty", tag, obs);
      return;
    end
    e = sb.pop_front();
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_lookup(input logic [31:0] pc, input logic et, input logic [31:0] etgt);
    lookup_en = 1'b1;
    lookup_pc = pc;
    #1;
    expect_val(64'(et));   chk("pred_taken", 64'(pred_taken));
    expect_val(64'(etgt)); chk("pred_target", 64'(pred_target));
    tick();
    lookup_en = 1'b0;
  endtask

  task automatic drive_update(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                              input logic ptk, input logic [31:0] ptgt);
    update_en          = 1'b1;
    update_pc          = pc;
    update_taken       = tk;
    update_target      = tgt;
    update_pred_taken  = ptk;
    update_pred_target = ptgt;
  endtask

  task automatic check_mis(input logic em, input logic [31:0] eredir);
    expect_val(64'(em)); chk("mispredict", 64'(mispredict));
    if (em) begin
      expect_val(64'(eredir)); chk("redirect_pc", 64'(redirect_pc));
    end
    br_exp++;
    if (em) miss_exp++;
  endtask

  task automatic do_update(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                           input logic ptk, input logic [31:0] ptgt,
                           input logic em, input logic [31:0] eredir);
    drive_update(pc, tk, tgt, ptk, ptgt);
    #1;
    check_mis(em, eredir);
    tick();
    update_en = 1'b0;
  endtask

  task automatic chk_stats();
    expect_val(64'(br_exp));   chk("br_count", 64'(br_count));
    expect_val(64'(miss_exp)); chk("miss_count", 64'(miss_count));
  endtask

  initial begin
    rst = 1'b1; clr_tbl = 1'b0; lookup_en = 1'b1; lookup_pc = 32'h100;
    drive_update(32'h100, 1'b1, 32'h200, 1'b0, 32'h0);
    #3;
    expect_val(64'd0); chk("rst_pred_taken", 64'(pred_taken));
    expect_val(64'd0); chk("rst_mispredict", 64'(mispredict));
    update_en = 1'b0; lookup_en = 1'b0;
    tick();
    rst = 1'b0;
    tick();

    // Cold miss: allocate 0x100 -> 0x200.
    do_update(32'h100, 1'b1, 32'h200, 1'b0, 32'h0, 1'b1, 32'h200);
    chk_stats();
    do_lookup(32'h100, 1'b1, 32'h200);

    // Saturation: 2 -> 3 -> 3 -> 3, then two not-taken steps.
    for (int i = 0; i < 3; i++)
      do_update(32'h100, 1'b1, 32'h200, 1'b1, 32'h200, 1'b0, 32'h0);
    do_update(32'h100, 1'b0, 32'h0, 1'b1, 32'h200, 1'b1, 32'h104);
    do_lookup(32'h100, 1'b1, 32'h200);
    do_update(32'h100, 1'b0, 32'h0, 1'b1, 32'h200, 1'b1, 32'h104);
    do_lookup(32'h100, 1'b0, 32'h104);

    // Target change with same-cycle lookup (pre-update contents: cnt=1).
    lookup_en = 1'b1; lookup_pc = 32'h100;
    drive_update(32'h100, 1'b1, 32'h300, 1'b1, 32'h200);
    #1;
    expect_val(64'd0);      chk("nobypass_taken", 64'(pred_taken));
    expect_val(64'h104);    chk("nobypass_target", 64'(pred_target));
    check_mis(1'b1, 32'h300);
    tick();
    update_en = 1'b0; lookup_en = 1'b0;
    do_lookup(32'h100, 1'b1, 32'h300);
    chk_stats();

    // Alias at idx 0 replaces 0x100.
    do_update(32'h140, 1'b1, 32'h500, 1'b0, 32'h0, 1'b1, 32'h500);
    do_lookup(32'h100, 1'b0, 32'h104);
    do_lookup(32'h140, 1'b1, 32'h500);

    // Not-taken miss writes nothing.
    do_update(32'h180, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    do_lookup(32'h140, 1'b1, 32'h500);
    do_update(32'h44, 1'b1, 32'h80, 1'b0, 32'h0, 1'b1, 32'h80);
    do_lookup(32'h44, 1'b1, 32'h80);
    chk_stats();

    // Asynchronous reset mid-cycle.
    #2;
    rst = 1'b1; lookup_en = 1'b1; lookup_pc = 32'h44;
    drive_update(32'h44, 1'b0, 32'h0, 1'b1, 32'h80);
    #1;
    expect_val(64'd0); chk("midrst_pred_taken", 64'(pred_taken));
    expect_val(64'd0); chk("midrst_mispredict", 64'(mispredict));
    expect_val(64'd0); chk("midrst_br_count", 64'(br_count));
    update_en = 1'b0; lookup_en = 1'b0;
    tick();
    rst = 1'b0; br_exp = 0; miss_exp = 0;
    do_lookup(32'h40, 1'b0, 32'h44);
    do_lookup(32'h44, 1'b0, 32'h48);
    chk_stats();

    // clr_tbl drops a concurrent update but statistics and mispredict still see it.
    do_update(32'h100, 1'b1, 32'h200, 1'b0, 32'h0, 1'b1, 32'h200);
    do_lookup(32'h100, 1'b1, 32'h200);
    clr_tbl = 1'b1;
    do_update(32'h140, 1'b1, 32'h600, 1'b0, 32'h0, 1'b1, 32'h600);
    clr_tbl = 1'b0;
    do_lookup(32'h100, 1'b0, 32'h104);
    do_lookup(32'h140, 1'b0, 32'h144);
    chk_stats();

    // Saturation of the 4-bit statistics instance.
    for (int i = 0; i < 20; i++)
      do_update(32'h800, 1'b1, 32'h900, 1'b0, 32'h0, 1'b1, 32'h900);
    expect_val(64'd15); chk("stat4_miss_count", 64'(miss_count4));
    expect_val(64'd15); chk("stat4_br_count", 64'(br_count4));
    tick();
    expect_val(64'd15); chk("stat4_miss_hold", 64'(miss_count4));
    chk_stats();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
